// File: rtl/twos_comp_seq_pkg.sv
// twos_comp_seq_pkg: shared width default and FSM state encoding for the serial negator
package twos_comp_seq_pkg;

    localparam int TC_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jk_flag.sv
// jk_flag: JK flip-flop with synchronous active-high reset
module jk_flag (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk)
        if (rst) q <= 1'b0;
        else     q <= (j & ~q) | (~k & q);

endmodule

// File: rtl/twos_comp_seq.sv
// twos_comp_seq: bit-serial two's complement negation, LSB first, one bit per clock
module twos_comp_seq
    import twos_comp_seq_pkg::*;
#(
    parameter int WIDTH = TC_WIDTH
) (
    input  logic             t_clk,
    input  logic             t_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, res, res_n;
    logic [CW-1:0]    cnt;
    logic             seen, load, last, in_shift;

    assign in_shift = state == SHIFT;
    assign load     = state == IDLE && start;
    assign last     = in_shift && cnt == CW'(WIDTH - 1);
    // bits up to and including the first 1 pass through; later bits invert
    assign res_n    = {sr[0] ^ seen, res[WIDTH-1:1]};
    assign busy     = in_shift;
    assign done     = state == DONE;

    jk_flag u_seen (
        .clk (t_clk),
        .rst (t_rst | load),
        .j   (in_shift & sr[0]),
        .k   (1'b0),
        .q   (seen)
    );

    always_comb begin
        state_n = state;
        state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            state <= IDLE;
            sr    <= '0;
            res   <= '0;
            cnt   <= '0;
            o     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                sr  <= x;
                res <= '0;
                cnt <= '0;
            end else if (in_shift) begin
                sr  <= sr >> 1;
                res <= res_n;
                cnt <= cnt + 1'b1;
            end
            // only the most negative operand negates to itself with MSB set alone
            if (last) begin
                o   <= res_n;
                ovf <= res_n == {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
    end

endmodule
